// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: serves HPS upload reads from a synchronous RAM.
// Each ioctl_rd strobe becomes one arbitrated RAM read (or FILL byte when out of range).
// It also keeps a session checksum and byte count.
// Ports:
//   clk_sys, reset_l (sync, active-low)
//   ioctl_upload/rd/addr in
//   ioctl_din/wait out
//   mem_addr/mem_rd out
//   mem_q/mem_grant in
//   checksum, byte_count, overrun, upload_done out
module ioctl_upload_reader #(
    parameter int          AW   = 13,
    parameter int          SIZE = 8192,
    parameter int          LAT  = 1,
    parameter logic [7:0]  FILL = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset_l,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_q,
    input  logic          mem_grant,
    output logic [7:0]    checksum,
    output logic [15:0]   byte_count,
    output logic          overrun,
    output logic          upload_done
);

    typedef enum logic [1:0] {IDLE, REQ, WAITQ} state_t;

    localparam logic [24:0] SIZE_A = 25'(SIZE);
    localparam logic [1:0]  LAT_V  = 2'(LAT);

    state_t      state;
    state_t      state_nxt;
    logic [24:0] addr_q;
    logic [1:0]  lat_cnt;
    logic        upload_q;

    logic        accept;
    logic        issue;
    logic        done_ram;
    logic        done_fill;
    logic        done;
    logic        oor;
    logic        rise;
    logic        fall;
    logic [7:0]  byte_nxt;
    logic [7:0]  sum_base;
    logic [15:0] cnt_base;

    // Range check uses the full 25-bit address; only the low AW bits reach the RAM.
    assign oor  = (addr_q >= SIZE_A);
    assign rise = ioctl_upload & ~upload_q;
    assign fall = ~ioctl_upload & upload_q;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        done_ram  = 1'b0;
        done_fill = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                if (ioctl_rd && ioctl_upload) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            (state == REQ): begin
                if (oor) begin
                    done_fill = 1'b1;
                    state_nxt = IDLE;
                end else if (mem_grant) begin
                    issue     = 1'b1;
                    state_nxt = WAITQ;
                end
            end
            (state == WAITQ): begin
                // lat_cnt reaches zero exactly in the cycle mem_q is valid
                if (lat_cnt == 2'd0) begin
                    done_ram  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign done     = done_ram | done_fill;
    assign byte_nxt = done_ram ? mem_q : FILL;
    // A session start clears first; a completion on the same edge adds onto zero.
    assign sum_base = rise ? 8'd0 : checksum;
    assign cnt_base = rise ? 16'd0 : byte_count;

    always_ff @(posedge clk_sys) begin
        if (!reset_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_l) begin
            addr_q      <= '0;
            lat_cnt     <= '0;
            upload_q    <= 1'b0;
            upload_done <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            ioctl_wait  <= 1'b0;
            ioctl_din   <= '0;
            checksum    <= '0;
            byte_count  <= '0;
            overrun     <= 1'b0;
        end else begin
            upload_q    <= ioctl_upload;
            upload_done <= fall;
            mem_rd      <= issue;
            if (accept) begin
                addr_q <= ioctl_addr;
            end
            if (issue) begin
                mem_addr <= addr_q[AW-1:0];
                lat_cnt  <= LAT_V;
            end else if (state == WAITQ && lat_cnt != 2'd0) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
            if (accept) begin
                ioctl_wait <= 1'b1;
            end else if (done) begin
                ioctl_wait <= 1'b0;
            end
            if (done) begin
                ioctl_din  <= byte_nxt;
                checksum   <= sum_base + byte_nxt;
                byte_count <= (cnt_base == 16'hFFFF) ? cnt_base
                                                     : cnt_base + 16'd1;
            end else begin
                checksum   <= sum_base;
                byte_count <= cnt_base;
            end
            if (ioctl_rd && state != IDLE) begin
                overrun <= 1'b1;
            end else if (rise) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// tb_ioctl_upload_reader: directed bench for ioctl_upload_reader.
// A behavioural 1-cycle-latency RAM is attached to the memory port.
module tb_ioctl_upload_reader;

    logic        clk_sys = 1'b0;
    logic        reset_l;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [12:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_q;
    logic        mem_grant;
    logic [7:0]  checksum;
    logic [15:0] byte_count;
    logic        overrun;
    logic        upload_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:8191];

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (mem_rd) mem_q <= ram[mem_addr];
    end

    ioctl_upload_reader #(
        .AW(13), .SIZE(8192), .LAT(1), .FILL(8'hFF)
    ) dut (
        .clk_sys(clk_sys),
        .reset_l(reset_l),
        .ioctl_upload(ioctl_upload),
        .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_q(mem_q),
        .mem_grant(mem_grant),
        .checksum(checksum),
        .byte_count(byte_count),
        .overrun(overrun),
        .upload_done(upload_done)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in cycle 1 after the strobe.
    task automatic strobe(input logic [24:0] a);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
    endtask

    task automatic rd_ram(input logic [24:0] a, input logic [7:0] exp);
        strobe(a);
        chk("c1_wait", ioctl_wait, 1);
        chk("c1_mem_rd", mem_rd, 0);
        tick();
        chk("c2_mem_rd", mem_rd, 1);
        chk("c2_mem_addr", mem_addr, a[12:0]);
        tick();
        chk("c3_wait", ioctl_wait, 1);
        chk("c3_mem_rd", mem_rd, 0);
        tick();
        chk("c4_wait", ioctl_wait, 0);
        chk("c4_din", ioctl_din, exp);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
        ram[0] = 8'h11;
        ram[1] = 8'h22;
        ram[2] = 8'h33;
        ram[3] = 8'h44;
        ram[5] = 8'h5A;
        reset_l      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        mem_grant    = 1'b1;
        tick();
        tick();
        chk("rst_din", ioctl_din, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_count", byte_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_done", upload_done, 0);

        // Read ignored without an upload session
        reset_l = 1'b1;
        strobe(25'd0);
        chk("no_session_wait", ioctl_wait, 0);
        tick();
        chk("no_session_mem_rd", mem_rd, 0);

        ioctl_upload = 1'b1;
        tick();
        tick();

        // Sequential RAM reads
        rd_ram(25'd0, 8'h11);
        rd_ram(25'd1, 8'h22);
        rd_ram(25'd2, 8'h33);
        rd_ram(25'd3, 8'h44);
        chk("seq_checksum", checksum, 8'hAA);
        chk("seq_count", byte_count, 4);

        // Out of range: FILL in cycle 2, no RAM access
        strobe(25'h2000);
        chk("oor_c1_wait", ioctl_wait, 1);
        chk("oor_c1_mem_rd", mem_rd, 0);
        tick();
        chk("oor_c2_wait", ioctl_wait, 0);
        chk("oor_c2_din", ioctl_din, 8'hFF);
        chk("oor_c2_mem_rd", mem_rd, 0);
        chk("oor_checksum", checksum, 8'hA9);
        chk("oor_count", byte_count, 5);

        // Upper address bits alone make it out of range
        strobe(25'h1000000);
        tick();
        chk("hi_din", ioctl_din, 8'hFF);
        chk("hi_mem_rd", mem_rd, 0);
        chk("hi_checksum", checksum, 8'hA8);
        chk("hi_count", byte_count, 6);

        // Grant stall
        mem_grant = 1'b0;
        strobe(25'd5);
        for (int i = 0; i < 10; i++) begin
            chk("stall_wait", ioctl_wait, 1);
            chk("stall_mem_rd", mem_rd, 0);
            if (i < 9) tick();
        end
        mem_grant = 1'b1;
        tick();
        chk("grant_mem_rd", mem_rd, 1);
        chk("grant_mem_addr", mem_addr, 5);
        tick();
        chk("grant_mem_rd_once", mem_rd, 0);
        chk("grant_wait", ioctl_wait, 1);
        tick();
        chk("grant_wait_low", ioctl_wait, 0);
        chk("grant_din", ioctl_din, 8'h5A);
        chk("grant_checksum", checksum, 8'h02);
        chk("grant_count", byte_count, 7);

        // Overrun: second strobe while busy is dropped
        strobe(25'd1);
        ioctl_addr = 25'd2;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
        chk("ovr_flag", overrun, 1);
        chk("ovr_mem_addr", mem_addr, 1);
        tick();
        tick();
        chk("ovr_din", ioctl_din, 8'h22);
        chk("ovr_wait", ioctl_wait, 0);
        tick();
        chk("ovr_count", byte_count, 8);
        chk("ovr_checksum", checksum, 8'h24);
        chk("ovr_sticky", overrun, 1);
        chk("ovr_no_extra_rd", mem_rd, 0);

        // Session end and restart
        ioctl_upload = 1'b0;
        tick();
        chk("end1_done", upload_done, 1);
        chk("end1_checksum", checksum, 8'h24);
        chk("end1_count", byte_count, 8);
        tick();
        chk("end1_done_pulse", upload_done, 0);
        ioctl_upload = 1'b1;
        tick();
        chk("rise_checksum", checksum, 0);
        chk("rise_count", byte_count, 0);
        chk("rise_overrun", overrun, 0);

        // Three bytes, then drop upload
        rd_ram(25'd0, 8'h11);
        rd_ram(25'd1, 8'h22);
        rd_ram(25'd2, 8'h33);
        ioctl_upload = 1'b0;
        tick();
        chk("end2_done", upload_done, 1);
        chk("end2_checksum", checksum, 8'h66);
        chk("end2_count", byte_count, 3);
        tick();
        chk("end2_done_pulse", upload_done, 0);
        chk("end2_hold_checksum", checksum, 8'h66);
        chk("end2_hold_count", byte_count, 3);

        // Restart with a strobe on the same cycle
        ioctl_upload = 1'b1;
        strobe(25'd3);
        chk("rise_rd_checksum", checksum, 0);
        chk("rise_rd_count", byte_count, 0);
        chk("rise_rd_wait", ioctl_wait, 1);
        tick();
        tick();
        tick();
        chk("rise_rd_din", ioctl_din, 8'h44);
        chk("rise_rd_checksum2", checksum, 8'h44);
        chk("rise_rd_count2", byte_count, 1);

        // Reset while waiting on RAM data
        strobe(25'd0);
        tick();
        chk("rst2_in_wait", mem_rd, 1);
        reset_l = 1'b0;
        tick();
        chk("rst2_wait", ioctl_wait, 0);
        chk("rst2_din", ioctl_din, 0);
        chk("rst2_checksum", checksum, 0);
        chk("rst2_count", byte_count, 0);
        reset_l = 1'b1;
        tick();
        rd_ram(25'd2, 8'h33);
        chk("rst2_after_checksum", checksum, 8'h33);
        chk("rst2_after_count", byte_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
